// File: rtl/core_pkg.sv
// Shared core definitions: control-bundle layout, ALU op codes, and the bubble-tracking state type.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package core_pkg;

    // Control bundle layout: {reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, alu_op[2:0]}
    localparam int CTRL_W          = 9;
    localparam int CTRL_REG_WRITE  = 8;
    localparam int CTRL_MEM_READ   = 7;
    localparam int CTRL_MEM_WRITE  = 6;
    localparam int CTRL_MEM_TO_REG = 5;
    localparam int CTRL_ALU_SRC    = 4;
    localparam int CTRL_BRANCH     = 3;
    localparam int CTRL_ALU_OP_MSB = 2;
    localparam int CTRL_ALU_OP_LSB = 0;

    // A NOP carries no side effects: every control bit low.
    localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

    // ALU operation classes handed from the decoder to the ALU control.
    typedef enum logic [2:0] {
        ALU_OP_ADD    = 3'b000,  // loads, stores, address math
        ALU_OP_BRANCH = 3'b001,  // compare for conditional branches
        ALU_OP_RTYPE  = 3'b010,  // funct3/funct7 decoded in EX
        ALU_OP_ITYPE  = 3'b011,  // immediate arithmetic
        ALU_OP_LUI    = 3'b100,
        ALU_OP_AUIPC  = 3'b101
    } alu_op_e;

    // Tracks whether the last non-held update of ID/EX inserted a load-use bubble.
    typedef enum logic {
        BUB_RUN    = 1'b0,
        BUB_BUBBLE = 1'b1
    } bub_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance events; sticks at all-ones instead of wrapping.
// Latency: count visible one cycle after the qualifying edge.
// Backpressure: en low freezes the count regardless of inc.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         en,
    output logic [W-1:0] cnt
);

    // Count one event per enabled cycle, stopping once every bit is set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en && inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: loads ID, or a NOP on flush / load-use bubble, and counts both events.
// Latency: 1 cycle, all outputs registered.
// Backpressure: hold freezes everything except a flush, which still kills the slot and counts.
module id_ex_pipe_reg import core_pkg::*; #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [8:0]        id_ctrl,
    input  logic              bubble_req,
    input  logic              flush,
    input  logic              hold,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [XLEN-1:0]   ex_imm,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [8:0]        ex_ctrl,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    bub_state_e bub_state;
    bub_state_e bub_state_nxt;

    // Flush wins over hold, so the register (and counters) advance on either.
    logic upd_en;
    assign upd_en = flush | ~hold;

    // Priority: reset, flush NOP, hold, bubble NOP, normal load.
    always_ff @(posedge clk) begin
        if (!rst_n || flush || (!hold && bubble_req)) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_ctrl     <= CTRL_NOP;
        end else if (!hold) begin
            ex_valid    <= id_valid;
            ex_pc       <= id_pc;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
            // An invalid slot must never carry write enables into EX.
            ex_ctrl     <= id_valid ? id_ctrl : CTRL_NOP;
        end
    end

    // Bubbles count only when actually inserted; a coincident flush takes precedence.
    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bubble_req & ~flush),
        .en    (upd_en),
        .cnt   (bubble_cnt)
    );

    // Flushes count only when they kill a real instruction.
    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush & id_valid),
        .en    (upd_en),
        .cnt   (flush_cnt)
    );

    // Bubble state register; held cycles leave it untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bub_state <= BUB_RUN;
        end else begin
            bub_state <= bub_state_nxt;
        end
    end

    // Next bubble state follows whichever update path this cycle takes.
    always_comb begin
        bub_state_nxt = bub_state;
        if (flush) begin
            bub_state_nxt = BUB_RUN;
        end else if (!hold) begin
            bub_state_nxt = bubble_req ? BUB_BUBBLE : BUB_RUN;
        end
    end

    // One bubble resolves a load-use hazard, so a second back-to-back request means a hazard-unit bug.
    always_ff @(posedge clk) begin
        if (rst_n && (bub_state == BUB_BUBBLE) && !hold && !flush) begin
            assert (!bubble_req);
        end
    end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: directed scenarios then randomized traffic against a reference model.
// Latency: compares outputs 1 time unit after each rising edge.
// Backpressure: stimulus never issues back-to-back bubbles on unheld cycles.
module tb_id_ex_pipe_reg;
    import core_pkg::*;

    localparam int XLEN   = 32;
    localparam int CNT_W  = 4;
    localparam int CNT_MX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             id_valid;
    logic [XLEN-1:0]  id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]       id_rs1, id_rs2, id_rd;
    logic [8:0]       id_ctrl;
    logic             bubble_req, flush, hold;
    logic             ex_valid;
    logic [XLEN-1:0]  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]       ex_rs1, ex_rs2, ex_rd;
    logic [8:0]       ex_ctrl;
    logic [CNT_W-1:0] bubble_cnt, flush_cnt;

    id_ex_pipe_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_ctrl(id_ctrl),
        .bubble_req(bubble_req), .flush(flush), .hold(hold),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
        .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: what EX should hold after each edge.
    bit        m_valid;
    bit [31:0] m_pc, m_rs1d, m_rs2d, m_imm;
    bit [4:0]  m_rs1, m_rs2, m_rd;
    bit [8:0]  m_ctrl;
    int        m_bcnt, m_fcnt;
    bit        m_last_bub;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_nop();
        m_valid = 0; m_pc = 0; m_rs1d = 0; m_rs2d = 0; m_imm = 0;
        m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_ctrl = 0;
    endtask

    // Applies the documented update rules to whatever is on the inputs right now.
    task automatic model_step();
        if (!rst_n) begin
            model_nop();
            m_bcnt = 0; m_fcnt = 0; m_last_bub = 0;
        end else if (flush) begin
            model_nop();
            if (id_valid) m_fcnt = (m_fcnt >= CNT_MX) ? CNT_MX : m_fcnt + 1;
            m_last_bub = 0;
        end else if (hold) begin
            // everything frozen
        end else if (bubble_req) begin
            model_nop();
            m_bcnt = (m_bcnt >= CNT_MX) ? CNT_MX : m_bcnt + 1;
            m_last_bub = 1;
        end else begin
            m_valid = id_valid;
            m_pc = id_pc; m_rs1d = id_rs1_data; m_rs2d = id_rs2_data; m_imm = id_imm;
            m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
            m_ctrl = id_valid ? id_ctrl : 9'h0;
            m_last_bub = 0;
        end
    endtask

    task automatic check_all();
        chk("ex_valid",    ex_valid,    m_valid);
        chk("ex_pc",       ex_pc,       m_pc);
        chk("ex_rs1_data", ex_rs1_data, m_rs1d);
        chk("ex_rs2_data", ex_rs2_data, m_rs2d);
        chk("ex_imm",      ex_imm,      m_imm);
        chk("ex_rs1",      ex_rs1,      m_rs1);
        chk("ex_rs2",      ex_rs2,      m_rs2);
        chk("ex_rd",       ex_rd,       m_rd);
        chk("ex_ctrl",     ex_ctrl,     m_ctrl);
        chk("bubble_cnt",  bubble_cnt,  m_bcnt);
        chk("flush_cnt",   flush_cnt,   m_fcnt);
    endtask

    // One clock: predict, take the edge, compare just after it.
    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic rand_id();
        id_valid    = ($urandom_range(3) != 0);
        id_pc       = $urandom;
        id_rs1_data = $urandom;
        id_rs2_data = $urandom;
        id_imm      = $urandom;
        id_rs1      = 5'($urandom);
        id_rs2      = 5'($urandom);
        id_rd       = 5'($urandom);
        id_ctrl     = 9'($urandom);
    endtask

    task automatic set_ctl(input bit b, input bit f, input bit h);
        bubble_req = b; flush = f; hold = h;
    endtask

    initial begin
        rst_n = 0;
        rand_id();
        set_ctl(0, 0, 0);
        m_last_bub = 0;

        // Reset with random inputs for two cycles.
        for (int i = 0; i < 2; i++) begin
            rand_id();
            set_ctl(1'($urandom), 1'($urandom), 1'($urandom));
            cyc();
        end
        chk("rst_valid", ex_valid, 0);
        chk("rst_ctrl", ex_ctrl, 0);
        chk("rst_bcnt", bubble_cnt, 0);

        // First instruction after reset release.
        rst_n = 1;
        set_ctl(0, 0, 0);
        rand_id();
        id_valid = 1; id_pc = 32'h100;
        id_ctrl = 9'h0;
        id_ctrl[CTRL_REG_WRITE] = 1'b1;
        id_ctrl[CTRL_ALU_OP_MSB:CTRL_ALU_OP_LSB] = ALU_OP_RTYPE;
        cyc();
        chk("rel_valid", ex_valid, 1);
        chk("rel_pc", ex_pc, 32'h100);
        chk("rel_ctrl", ex_ctrl, 9'h102);

        // Load-use bubble for one cycle, then the held instruction loads.
        rand_id(); id_valid = 1; id_rd = 5'd5;
        set_ctl(1, 0, 0);
        cyc();
        chk("lu_valid", ex_valid, 0);
        chk("lu_ctrl", ex_ctrl, 0);
        chk("lu_bcnt", bubble_cnt, 1);
        set_ctl(0, 0, 0);
        cyc();
        chk("lu_rd", ex_rd, 5);
        chk("lu_valid2", ex_valid, 1);

        // Flush together with bubble request: valid slot then invalid slot.
        rand_id(); id_valid = 1;
        set_ctl(1, 1, 0);
        cyc();
        chk("fb_fcnt", flush_cnt, 1);
        chk("fb_bcnt", bubble_cnt, 1);
        chk("fb_valid", ex_valid, 0);
        rand_id(); id_valid = 0;
        cyc();
        chk("fb_fcnt_inv", flush_cnt, 1);

        // Hold for three cycles with a pending bubble, then release.
        rand_id(); id_valid = 1; id_pc = 32'h200;
        set_ctl(0, 0, 0);
        cyc();
        for (int i = 0; i < 3; i++) begin
            rand_id();
            set_ctl(1, 0, 1);
            cyc();
            chk("hold_pc", ex_pc, 32'h200);
            chk("hold_bcnt", bubble_cnt, 1);
        end
        set_ctl(1, 0, 0);
        cyc();
        chk("hold_rel_bcnt", bubble_cnt, 2);
        chk("hold_rel_valid", ex_valid, 0);

        // Invalid slot must drop all control bits.
        rand_id(); id_valid = 0; id_ctrl = 9'h1FF;
        set_ctl(0, 0, 0);
        cyc();
        chk("mask_ctrl", ex_ctrl, 0);
        chk("mask_valid", ex_valid, 0);

        // Saturation: twenty bubbles, each followed by a normal cycle.
        for (int i = 0; i < 20; i++) begin
            rand_id(); set_ctl(1, 0, 0); cyc();
            rand_id(); set_ctl(0, 0, 0); cyc();
        end
        chk("sat_bcnt", bubble_cnt, 4'hF);
        rand_id(); set_ctl(1, 0, 0); cyc();
        chk("sat_stay", bubble_cnt, 4'hF);
        rst_n = 0;
        rand_id(); set_ctl(0, 0, 0);
        cyc();
        chk("mid_rst_bcnt", bubble_cnt, 0);
        chk("mid_rst_valid", ex_valid, 0);
        rst_n = 1;

        // Random traffic with occasional reset.
        for (int i = 0; i < 2000; i++) begin
            rand_id();
            rst_n = ($urandom_range(63) != 0);
            set_ctl(($urandom_range(3) == 0), ($urandom_range(7) == 0), ($urandom_range(5) == 0));
            if (m_last_bub && !hold && !flush) bubble_req = 0;
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe_reg.md
# id_ex_pipe_reg

ID/EX pipeline register for the five-stage RISC-V core, and the consuming end of the load-use hazard interface. The hazard unit raises a bubble request when an instruction in ID needs the result of a load still in EX. This block turns that request into an actual NOP bubble in EX, and it also applies branch flushes and downstream holds. It owns the valid bit and the control bundle that travel with each instruction into EX, and it keeps bubble and flush counters for performance analysis.

## Interface
Parameters:
- XLEN, 32, datapath width (PC, operands, immediate)
- CNT_W, 32, width of the bubble and flush counters

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst_n  in  1  synchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_pc, id_rs1_data, id_rs2_data, id_imm  in  XLEN each  ID datapath values
- id_rs1, id_rs2, id_rd  in  5 each  register indices
- id_ctrl  in  9  {reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, alu_op[2:0]}
- bubble_req  in  1  load-use stall from the hazard unit; IF/ID holds elsewhere, this block inserts a NOP
- flush  in  1  taken branch/jump resolved in EX; kill the instruction entering EX
- hold  in  1  downstream (MEM) stall; freeze this register
- ex_valid  out  1  EX instruction is real
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN each
- ex_rs1, ex_rs2, ex_rd  out  5 each
- ex_ctrl  out  9  control bundle; all-zero whenever ex_valid=0
- bubble_cnt, flush_cnt  out  CNT_W each  event counters

## Operation
- Priority each cycle, first match wins:
  1. reset
  2. flush: load a NOP
  3. hold: keep all state
  4. bubble_req: load a NOP
  5. normal: load from the id_* inputs
- A NOP sets ex_valid=0, ex_ctrl=0 and ex_rd/ex_rs1/ex_rs2=0. Datapath fields are don't-care but are driven to 0, so waveforms stay deterministic.
- In the normal path, ex_valid=id_valid. If id_valid=0, ex_ctrl is forced to 0 regardless of id_ctrl. This guarantees that an invalid slot never writes memory or the register file.
- ex_rd=0 with reg_write=1 is passed through unchanged. The register file ignores x0.
- bubble_cnt increments by 1 on every cycle that takes path 4.
- flush_cnt increments by 1 on every cycle that takes path 2 while the slot being killed (incoming id_valid) is 1.
- Both counters saturate at all-ones. They do not wrap.
- hold freezes the counters. Flush overrides hold, so flush_cnt still counts during hold.
- The bubble state is a 2-state view (RUN, BUBBLE) derived from the last update path. It is used only for the assertion that bubble_req is never asserted on two consecutive non-hold cycles for the same instruction. It drives no outputs.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- Reset values: every output is 0, including ex_valid=0, ex_ctrl=0 and both counters. Reset applies only on an edge with rst_n=0.
- Reset asserted mid-stream discards the EX instruction. There is no partial-update state.
- Simultaneous events:
  - flush+bubble_req: one NOP, and only flush_cnt counts.
  - hold+bubble_req: state is held, and bubble_req is expected to persist. bubble_cnt counts only when the bubble is actually inserted.
  - flush+hold: NOP is inserted.
- All outputs come straight from registers. There is no combinational path from any input to any output.

## Structure
- Shared package core_pkg:
  - field positions of the control bundle: CTRL_REG_WRITE … CTRL_ALU_OP_LSB
  - CTRL_W=9
  - CTRL_NOP='0
  - the alu_op encodings
- The same package is used by the decoder and by the EX/MEM register.
- Sub-module: sat_counter (parameters W; ports inc, en), instantiated twice for bubble_cnt and flush_cnt.
- Everything else is flat.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with random inputs. Required: all outputs 0. Release with id_valid=1, id_pc=0x100, ctrl=reg_write|alu_op=3'b010. Required: next cycle ex_valid=1, ex_pc=0x100, ex_ctrl matches.
- Load-use: pulse bubble_req for 1 cycle with id carrying a valid instruction (rd=5). Required: next cycle ex_valid=0, ex_ctrl=0, bubble_cnt=1. On the following cycle the instruction loads normally.
- Flush vs. bubble: assert flush and bubble_req together with id_valid=1. Required: NOP, flush_cnt=1, bubble_cnt unchanged. Repeat with id_valid=0: flush_cnt is unchanged.
- Hold: load pc=0x200, then assert hold for 3 cycles while the id inputs change and bubble_req=1. Required: outputs remain pc=0x200 and both counters are unchanged. On release a bubble is inserted and bubble_cnt increments.
- Invalid slot masking: id_valid=0 with id_ctrl=9'h1FF. Required: ex_ctrl=0 and ex_valid=0.
- Saturation: with CNT_W=4, apply 20 bubbles. Required: bubble_cnt=4'hF and it stays at 4'hF. Then assert reset mid-run: bubble_cnt=0 and ex_valid=0 on the next cycle.
